// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load register with a serial right shift; ser_in enters at the MSB.
module serial_shift_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (shift)
            q <= {ser_in, q[WIDTH-1:1]};
    end

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder, one bit per clock, with registered S/Cout/Ovf.
// Define SERIAL_ADD_SUB_EN to add the Sub port (A - B in two's complement).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             Sub,
`endif
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             sub_q;
    logic             sub_in;
    logic [WIDTH-1:0] a_q, b_q, r_q;
    logic             load, shift, last;
    logic             b_bit, sum_bit, carry_nxt;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_in = Sub;
`else
    assign sub_in = 1'b0;
`endif

    assign load  = (state == IDLE) && Start;
    assign shift = (state == SHIFT);
    assign last  = (cnt == CW'(WIDTH - 1));

    // Inverting B on the fly plus carry-in = 1 turns the add into A - B.
    assign b_bit     = b_q[0] ^ sub_q;
    assign sum_bit   = a_q[0] ^ b_bit ^ carry;
    assign carry_nxt = (a_q[0] & b_bit) | (a_q[0] & carry) | (b_bit & carry);

    serial_shift_reg #(.WIDTH(WIDTH)) u_a (
        .clk(Clk), .rst(Reset), .load(load), .load_val(A),
        .shift(shift), .ser_in(1'b0), .q(a_q)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_b (
        .clk(Clk), .rst(Reset), .load(load), .load_val(B),
        .shift(shift), .ser_in(1'b0), .q(b_q)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_r (
        .clk(Clk), .rst(Reset), .load(load), .load_val('0),
        .shift(shift), .ser_in(sum_bit), .q(r_q)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            sub_q <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        carry <= sub_in;
                        sub_q <= sub_in;
                    end
                end
                SHIFT: begin
                    cnt   <= cnt + 1'b1;
                    carry <= carry_nxt;
                    // On the final bit the result register still lacks the MSB, so assemble it here.
                    if (last) begin
                        state <= DONE;
                        S     <= {sum_bit, r_q[WIDTH-1:1]};
                        Cout  <= carry_nxt;
                        Ovf   <= carry ^ carry_nxt;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy = (state == SHIFT);
    assign Done = (state == DONE);

endmodule
